typed_operand_stack: RTL and testbench
======================================

# typed_operand_stack

Parametrised, type-tagged operand stack for the WebAssembly core, replacing the fixed single-width value stack. Each entry holds a value plus its wasm type byte. The block executes PUSH/POP/DROP/CLEAR in one cycle and a multi-cycle, type-checked SELECT. Faults are reported on the core's 4-bit `trap` bus using the `core.svh` trap macros, with the same semantics the core already exposes (e.g. `TYPES_MISMATCH` on an ill-typed `select`).

## Interface
- `WIDTH`, 64: value width in bits (≥32).
- `DEPTH`, 16: number of entries (power of two, ≥4).
- `TYPED`, 1: 1 = enforce type checks on SELECT; 0 = untyped mode, no checks.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op_valid` in 1: operation request.
- `op` in 3: 0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 SELECT, 5 CLEAR; 6–7 treated as NOP.
- `op_ready` out 1: block can accept an op this cycle.
- `push_data` in WIDTH: value for PUSH.
- `push_type` in 8: wasm type byte for PUSH (0x7F i32, 0x7E i64, 0x7D f32, 0x7C f64).
- `result` out WIDTH: top-of-stack value (0 when empty).
- `result_type` out 8: top-of-stack type (0x00 when empty).
- `result_empty` out 1: stack holds zero entries.
- `count` out $clog2(DEPTH)+1: current entry count.
- `trap` out 4: `NONE`, `STACK_UNDERFLOW`, `STACK_OVERFLOW`, `TYPES_MISMATCH` (core.svh macros).

## Operation
- Handshake: an op is accepted on a rising edge where `op_valid & op_ready`. `op_ready` = (state == IDLE) & (trap == `NONE`).
- FSM states: IDLE, SEL_CHECK, SEL_WRITE, HALT.
- PUSH: if count == DEPTH, set trap `STACK_OVERFLOW` and enter HALT. Otherwise write {push_type, push_data} at index count, count+1.
- POP / DROP: if count == 0, set `STACK_UNDERFLOW` and enter HALT. Otherwise count−1. POP and DROP behave identically; the popped value is visible on `result` in the accepting cycle.
- CLEAR: count ← 0. Never traps.
- SELECT (wasm `select`): operands are c = top, b = top−1, a = top−2.
  - Accept with count < 3 → `STACK_UNDERFLOW`, HALT, stack untouched.
  - Otherwise latch a, b, c with their types and go to SEL_CHECK.
  - SEL_CHECK, TYPED=1: c type ≠ 0x7F, or a type ≠ b type → trap `TYPES_MISMATCH`, HALT, stack untouched.
  - SEL_CHECK, otherwise: go to SEL_WRITE.
  - SEL_WRITE: count ← count−2; entry at new top ← (c[31:0] ≠ 0) ? a : b, including type byte. Then return to IDLE.
- Condition uses only bits [31:0] of c, regardless of WIDTH.
- HALT is absorbing. Trap is sticky; only `reset` leaves it. Ops presented in HALT are not accepted.
- `result`, `result_type`, `result_empty` are combinational from storage[count−1] and count.

## Timing
- Reset values: count 0, state IDLE, trap `NONE`, `result` 0, `result_type` 0x00, `result_empty` 1, `op_ready` 1. Storage contents need not be reset.
- PUSH/POP/DROP/CLEAR accepted at edge E: new count and top visible right after E. Back-to-back issue every cycle.
- SELECT accepted at edge E:
  - `op_ready` low for the two cycles after E.
  - Result committed at E+2; `op_ready` high again after E+2.
  - A type mismatch sets trap at E+1, and `op_ready` stays low thereafter.
- Underflow/overflow traps are visible immediately after the accepting edge.
- Stack contents and count are frozen from the trapping edge on.
- Reset asserted mid-SELECT: immediate return to reset values; the partial select is discarded.
- Push to exactly DEPTH entries succeeds. The next PUSH traps.
- NOP accepted in IDLE has no effect.

## Test plan
- Reset, then PUSH i32 5, PUSH i32 9, PUSH i32 1, SELECT → after 3 cycles count 1, `result` 5, `result_type` 0x7F, trap `NONE`.
- PUSH i64 0x1_0000_0000, PUSH i64 7, PUSH i32 0, SELECT → `result` 7, `result_type` 0x7E; `op_ready` low exactly 2 cycles.
- PUSH i32 1, PUSH i64 2, PUSH i32 1, SELECT → trap `TYPES_MISMATCH` one cycle after accept, count stays 3, `op_ready` stuck 0. Same stack with TYPED=0 → `result` 1, no trap.
- PUSH f32, PUSH f32, PUSH i64 (cond), SELECT → `TYPES_MISMATCH`. Separately, SELECT with count 2 → `STACK_UNDERFLOW`, count 2.
- DEPTH=4: five PUSHes → first four succeed (count 4), fifth sets `STACK_OVERFLOW`. POP on empty after reset → `STACK_UNDERFLOW`, `result_empty` 1.
- Assert `reset` one cycle after a SELECT is accepted → all outputs at reset values next cycle. A subsequent PUSH i32 3 → `result` 3.

Source files
------------

// File: rtl/typed_operand_stack.sv
// ---------------------------------------------------------------------------
// typed_operand_stack : type-tagged wasm operand stack with a checked SELECT
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module typed_operand_stack #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16,
   parameter bit TYPED = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     op_valid,
   input  logic [2:0]               op,
   output logic                     op_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic [7:0]               push_type,
   output logic [WIDTH-1:0]         result,
   output logic [7:0]               result_type,
   output logic                     result_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [3:0]               trap
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] c_OP_PUSH   = 3'd1;
   localparam logic [2:0] c_OP_POP    = 3'd2;
   localparam logic [2:0] c_OP_DROP   = 3'd3;
   localparam logic [2:0] c_OP_SELECT = 3'd4;
   localparam logic [2:0] c_OP_CLEAR  = 3'd5;

   localparam logic [3:0] c_TRAP_NONE            = 4'h0;
   localparam logic [3:0] c_TRAP_STACK_UNDERFLOW = 4'h1;
   localparam logic [3:0] c_TRAP_STACK_OVERFLOW  = 4'h2;
   localparam logic [3:0] c_TRAP_TYPES_MISMATCH  = 4'h3;

   localparam logic [7:0]    c_TYPE_I32 = 8'h7F;
   localparam logic [CW-1:0] c_FULL     = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEL_CHECK = 2'd1,
      S_SEL_WRITE = 2'd2,
      S_HALT      = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_count, w_count_nxt;
   logic [3:0]      r_trap, w_trap_nxt;

   logic [WIDTH-1:0] r_val [DEPTH];
   logic [7:0]       r_typ [DEPTH];

   // Operands captured at SELECT accept; only the low word of c is a condition.
   logic [WIDTH-1:0] r_a_val, r_b_val;
   logic [7:0]       r_a_typ, r_b_typ, r_c_typ;
   logic [31:0]      r_c_cond;

   logic             w_accept;
   logic             w_latch;
   logic             w_wr_en;
   logic [AW-1:0]    w_wr_idx;
   logic [WIDTH-1:0] w_wr_val;
   logic [7:0]       w_wr_typ;
   logic [AW-1:0]    w_idx_top, w_idx_b, w_idx_a;

   assign w_idx_top = r_count[AW-1:0] - AW'(1);
   assign w_idx_b   = r_count[AW-1:0] - AW'(2);
   assign w_idx_a   = r_count[AW-1:0] - AW'(3);

   assign op_ready     = (r_state == S_IDLE) && (r_trap == c_TRAP_NONE);
   assign w_accept     = op_valid && op_ready;
   assign count        = r_count;
   assign trap         = r_trap;
   assign result_empty = (r_count == '0);
   assign result       = result_empty ? '0 : r_val[w_idx_top];
   assign result_type  = result_empty ? 8'h00 : r_typ[w_idx_top];

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_trap_nxt  = r_trap;
      w_latch     = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_count[AW-1:0];
      w_wr_val    = push_data;
      w_wr_typ    = push_type;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (op)
                  c_OP_PUSH: begin
                     if (r_count == c_FULL) begin
                        w_trap_nxt  = c_TRAP_STACK_OVERFLOW;
                        w_state_nxt = S_HALT;
                     end else begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = r_count + CW'(1);
                     end
                  end
                  c_OP_POP, c_OP_DROP: begin
                     if (r_count == '0) begin
                        w_trap_nxt  = c_TRAP_STACK_UNDERFLOW;
                        w_state_nxt = S_HALT;
                     end else begin
                        w_count_nxt = r_count - CW'(1);
                     end
                  end
                  c_OP_SELECT: begin
                     if (r_count < CW'(3)) begin
                        w_trap_nxt  = c_TRAP_STACK_UNDERFLOW;
                        w_state_nxt = S_HALT;
                     end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_SEL_CHECK;
                     end
                  end
                  c_OP_CLEAR: w_count_nxt = '0;
                  default: ;
               endcase
            end
         end
         S_SEL_CHECK: begin
            if (TYPED && ((r_c_typ != c_TYPE_I32) || (r_a_typ != r_b_typ))) begin
               w_trap_nxt  = c_TRAP_TYPES_MISMATCH;
               w_state_nxt = S_HALT;
            end else begin
               w_state_nxt = S_SEL_WRITE;
            end
         end
         S_SEL_WRITE: begin
            // Three operands collapse into one result at the old a slot.
            w_wr_en     = 1'b1;
            w_wr_idx    = w_idx_a;
            w_wr_val    = (r_c_cond != 32'd0) ? r_a_val : r_b_val;
            w_wr_typ    = (r_c_cond != 32'd0) ? r_a_typ : r_b_typ;
            w_count_nxt = r_count - CW'(2);
            w_state_nxt = S_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_trap  <= c_TRAP_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_trap  <= w_trap_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_val[w_wr_idx] <= w_wr_val;
         r_typ[w_wr_idx] <= w_wr_typ;
      end
      if (w_latch) begin
         r_a_val  <= r_val[w_idx_a];
         r_a_typ  <= r_typ[w_idx_a];
         r_b_val  <= r_val[w_idx_b];
         r_b_typ  <= r_typ[w_idx_b];
         r_c_typ  <= r_typ[w_idx_top];
         r_c_cond <= r_val[w_idx_top][31:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_typed_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_typed_operand_stack : scoreboard bench, typed/16-deep and untyped/4-deep
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_typed_operand_stack;

   localparam logic [3:0] T_NONE  = 4'h0;
   localparam logic [3:0] T_UNDER = 4'h1;
   localparam logic [3:0] T_OVER  = 4'h2;
   localparam logic [3:0] T_MISM  = 4'h3;
   localparam logic [7:0] I32 = 8'h7F, I64 = 8'h7E, F32 = 8'h7D, F64 = 8'h7C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [63:0] push_data;
   logic [7:0]  push_type;

   logic        rdy0, rdy1, emp0, emp1;
   logic [63:0] res0, res1;
   logic [7:0]  rty0, rty1;
   logic [4:0]  cnt0;
   logic [2:0]  cnt1;
   logic [3:0]  trp0, trp1;

   typed_operand_stack #(.WIDTH(64), .DEPTH(16), .TYPED(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(rdy0),
      .push_data(push_data), .push_type(push_type), .result(res0),
      .result_type(rty0), .result_empty(emp0), .count(cnt0), .trap(trp0));

   typed_operand_stack #(.WIDTH(64), .DEPTH(4), .TYPED(1'b0)) u_dut1 (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(rdy1),
      .push_data(push_data), .push_type(push_type), .result(res1),
      .result_type(rty1), .result_empty(emp1), .count(cnt1), .trap(trp1));

   // Reference model: an array-backed stack plus a select countdown.
   typedef struct packed {
      logic [63:0] v;
      logic [7:0]  t;
   } entry_t;

   typedef struct packed {
      logic [63:0] res;
      logic [7:0]  rty;
      logic        emp;
      logic [7:0]  cnt;
      logic [3:0]  trp;
      logic        rdy;
   } exp_t;

   entry_t     mem [2][16];
   int         mcnt [2];
   int         phase [2];
   logic [3:0] mtrap [2];
   int         depth_of [2];
   bit         typed_of [2];

   exp_t q0[$];
   exp_t q1[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   function automatic exp_t snap(input int i);
      exp_t e;
      e.emp = (mcnt[i] == 0);
      e.res = e.emp ? 64'd0 : mem[i][mcnt[i]-1].v;
      e.rty = e.emp ? 8'h00 : mem[i][mcnt[i]-1].t;
      e.cnt = 8'(mcnt[i]);
      e.trp = mtrap[i];
      e.rdy = (phase[i] == 0) && (mtrap[i] == T_NONE);
      return e;
   endfunction

   task automatic model_reset(input int i);
      mcnt[i]  = 0;
      phase[i] = 0;
      mtrap[i] = T_NONE;
   endtask

   task automatic model_step(input int i);
      entry_t a, b, c;
      logic [31:0] cond;
      if (reset) begin
         model_reset(i);
         return;
      end
      if (mtrap[i] != T_NONE) return;
      if (phase[i] != 0) begin
         a = mem[i][mcnt[i]-3];
         b = mem[i][mcnt[i]-2];
         c = mem[i][mcnt[i]-1];
         if (phase[i] == 1) begin
            if (typed_of[i] && (c.t != I32 || a.t != b.t)) begin
               mtrap[i] = T_MISM;
               phase[i] = 0;
            end else begin
               phase[i] = 2;
            end
         end else begin
            cond = c.v[31:0];
            mcnt[i] = mcnt[i] - 2;
            mem[i][mcnt[i]-1] = (cond != 0) ? a : b;
            phase[i] = 0;
         end
      end else if (op_valid) begin
         case (op)
            3'd1: if (mcnt[i] == depth_of[i]) mtrap[i] = T_OVER;
                  else begin
                     mem[i][mcnt[i]] = '{v: push_data, t: push_type};
                     mcnt[i]++;
                  end
            3'd2, 3'd3: if (mcnt[i] == 0) mtrap[i] = T_UNDER; else mcnt[i]--;
            3'd4: if (mcnt[i] < 3) mtrap[i] = T_UNDER; else phase[i] = 1;
            3'd5: mcnt[i] = 0;
            default: ;
         endcase
      end
   endtask

   // One clock: advance the model on the edge, then present the next inputs.
   task automatic cycle(input bit r, input bit v, input logic [2:0] o,
                        input logic [63:0] d, input logic [7:0] t);
      @(posedge clk);
      model_step(0);
      model_step(1);
      cyc++;
      #2;
      reset = r; op_valid = v; op = o; push_data = d; push_type = t;
      if (r) begin
         model_reset(0);
         model_reset(1);
      end
      q0.push_back(snap(0));
      q1.push_back(snap(1));
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 3'd0, 64'd0, 8'h00);
      cycle(1'b1, 1'b0, 3'd0, 64'd0, 8'h00);
      cycle(1'b0, 1'b0, 3'd0, 64'd0, 8'h00);
   endtask

   task automatic push(input logic [7:0] t, input logic [63:0] d);
      cycle(1'b0, 1'b1, 3'd1, d, t);
   endtask

   task automatic issue(input logic [2:0] o);
      cycle(1'b0, 1'b1, o, 64'd0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 3'd0, 64'd0, 8'h00);
   endtask

   task automatic chk(input string name, input int inst,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL dut%0d cycle %0d %s: got 0x%0h expected 0x%0h",
                  inst, cyc, name, act, exp);
      end
   endtask

   task automatic compare(input int inst, input exp_t e, input logic [63:0] res,
                          input logic [7:0] rty, input logic emp, input logic [7:0] cnt,
                          input logic [3:0] trp, input logic rdy);
      chk("result", inst, res, e.res);
      chk("result_type", inst, 64'(rty), 64'(e.rty));
      chk("result_empty", inst, 64'(emp), 64'(e.emp));
      chk("count", inst, 64'(cnt), 64'(e.cnt));
      chk("trap", inst, 64'(trp), 64'(e.trp));
      chk("op_ready", inst, 64'(rdy), 64'(e.rdy));
   endtask

   exp_t m0, m1;
   always @(negedge clk) begin
      if (q0.size() > 0) begin
         m0 = q0.pop_front();
         compare(0, m0, res0, rty0, emp0, 8'(cnt0), trp0, rdy0);
      end
      if (q1.size() > 0) begin
         m1 = q1.pop_front();
         compare(1, m1, res1, rty1, emp1, 8'(cnt1), trp1, rdy1);
      end
   end

   function automatic logic [7:0] rand_type();
      case ($urandom_range(0, 3))
         0: return I32;
         1: return I64;
         2: return F32;
         default: return F64;
      endcase
   endfunction

   initial begin
      depth_of[0] = 16; typed_of[0] = 1'b1;
      depth_of[1] = 4;  typed_of[1] = 1'b0;
      model_reset(0);
      model_reset(1);
      reset = 1'b1; op_valid = 1'b0; op = 3'd0; push_data = '0; push_type = '0;

      do_reset();
      push(I32, 64'd5); push(I32, 64'd9); push(I32, 64'd1);
      issue(3'd4); idle(4);

      do_reset();
      push(I64, 64'h1_0000_0000); push(I64, 64'd7); push(I32, 64'd0);
      issue(3'd4); idle(4);

      do_reset();
      push(I32, 64'd1); push(I64, 64'd2); push(I32, 64'd1);
      issue(3'd4); issue(3'd1); idle(3);

      do_reset();
      push(F32, 64'h3F80_0000); push(F32, 64'h4000_0000); push(I64, 64'd1);
      issue(3'd4); idle(3);

      do_reset();
      push(I32, 64'd4); push(I32, 64'd6); issue(3'd4); issue(3'd2); idle(2);

      do_reset();
      for (int k = 0; k < 17; k++) push(I64, 64'(k + 100));
      idle(2);

      do_reset();
      issue(3'd2); idle(2);

      do_reset();
      push(I32, 64'd11); push(I32, 64'd22); issue(3'd5); issue(3'd0);
      issue(3'd6); push(F64, 64'hDEAD); issue(3'd3); idle(2);

      do_reset();
      push(I32, 64'd1); push(I32, 64'd2); push(I32, 64'd1);
      issue(3'd4);
      cycle(1'b1, 1'b0, 3'd0, 64'd0, 8'h00);
      cycle(1'b0, 1'b1, 3'd1, 64'd3, I32);
      idle(3);

      for (int s = 0; s < 8; s++) begin
         do_reset();
         for (int k = 0; k < 40; k++) begin
            int r;
            logic [2:0] o;
            logic [63:0] d;
            logic [7:0] t;
            r = $urandom_range(0, 99);
            if (r < 45)      o = 3'd1;
            else if (r < 58) o = 3'd2;
            else if (r < 63) o = 3'd3;
            else if (r < 82) o = 3'd4;
            else if (r < 86) o = 3'd5;
            else if (r < 93) o = 3'd0;
            else             o = 3'($urandom_range(6, 7));
            if ($urandom_range(0, 1) == 0) d = 64'($urandom_range(0, 2));
            else d = {32'($urandom), 32'($urandom)};
            t = ($urandom_range(0, 2) == 0) ? rand_type() : I32;
            cycle(1'b0, ($urandom_range(0, 9) != 0), o, d, t);
         end
      end

      idle(1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", 0, 64'(q0.size() + q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
